// File: rtl/gpio_cmd_responder_pkg.sv
// Shared opcodes, FSM states and GPIO word field positions for the command responder.
package gpio_cmd_responder_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_WR_KERNEL = 3'd1,
        OP_WR_PIXEL  = 3'd2,
        OP_SOP       = 3'd3,
        OP_EOP       = 3'd4,
        OP_RD_RESULT = 3'd5,
        OP_STATUS    = 3'd6,
        OP_FLUSH     = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Command word layout
    localparam int CMD_OP_HI   = 31;
    localparam int CMD_OP_LO   = 29;
    localparam int CMD_REQ_BIT = 28;
    localparam int CMD_ADDR_HI = 11;
    localparam int CMD_ADDR_LO = 8;
    localparam int CMD_DATA_HI = 7;
    localparam int CMD_DATA_LO = 0;

    // Response word layout: {ack, opcode, error, payload}
    localparam int RSP_PAYLOAD_W = 27;

endpackage

// File: rtl/gpio_cmd_responder_result_fifo.sv
// Synchronous result FIFO with sticky overflow flag and single-cycle flush.
module gpio_cmd_responder_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              ck_rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow
);

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (int'(count) == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees a slot, so full+pop+push is a legal push.
    assign do_push = push && !flush && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!ck_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_cmd_responder.sv
// GPIO command responder: toggle-handshake decode, conv-core strobes and result/status return.
module gpio_cmd_responder
    import gpio_cmd_responder_pkg::*;
#(
    parameter int GPIO_D     = 32,
    parameter int BIT_LEN    = 8,
    parameter int M_LEN      = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               CLK100MHZ,
    input  logic               ck_rst,
    input  logic [GPIO_D-1:0]  i_gpio_data,
    output logic [GPIO_D-1:0]  o_gpio_data,
    output logic [BIT_LEN-1:0] o_kernel_data,
    output logic [3:0]         o_kernel_addr,
    output logic               o_kernel_we,
    output logic [BIT_LEN-1:0] o_pixel_data,
    output logic               o_pixel_valid,
    output logic               o_sop,
    output logic               o_eop,
    input  logic [BIT_LEN-1:0] i_result_data,
    input  logic               i_result_valid,
    output logic [2:0]         o_led
);

    state_t                   state;
    state_t                   state_nxt;
    opcode_t                  cmd_op;
    logic                     req_q;
    logic [3:0]               cmd_addr;
    logic [7:0]               cmd_data;
    logic                     ack_q;
    opcode_t                  rsp_op;
    logic                     rsp_err;
    logic [RSP_PAYLOAD_W-1:0] rsp_payload;
    logic                     rsp_err_nxt;
    logic [RSP_PAYLOAD_W-1:0] rsp_payload_nxt;

    logic                     exec;
    logic                     cmd_load;
    logic                     kernel_ok;
    logic                     fifo_pop;
    logic                     fifo_flush;
    logic [BIT_LEN-1:0]       fifo_rd_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_AW:0]         fifo_count;
    logic                     fifo_overflow;
    logic                     unused_bits;

    assign unused_bits = ^{i_gpio_data[27:12], fifo_full};

    assign exec       = (state == ST_EXEC);
    // Freeze the command once a request is seen so EXEC/ACK act on a stable word.
    assign cmd_load   = (state == ST_IDLE) && (req_q == ack_q);
    assign kernel_ok  = (int'(cmd_addr) < M_LEN * M_LEN);
    assign fifo_pop   = exec && (cmd_op == OP_RD_RESULT) && !fifo_empty;
    assign fifo_flush = exec && (cmd_op == OP_FLUSH);

    gpio_cmd_responder_result_fifo #(
        .DATA_W (BIT_LEN),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_result_fifo (
        .clk      (CLK100MHZ),
        .ck_rst   (ck_rst),
        .push     (i_result_valid),
        .wr_data  (i_result_data),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_overflow)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_q != ack_q) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_err_nxt     = 1'b0;
        rsp_payload_nxt = '0;
        case (cmd_op)
            OP_WR_KERNEL: rsp_err_nxt = !kernel_ok;
            OP_RD_RESULT: begin
                if (fifo_empty) begin
                    rsp_err_nxt = 1'b1;
                end else begin
                    rsp_payload_nxt = RSP_PAYLOAD_W'(fifo_rd_data);
                end
            end
            OP_STATUS:    rsp_payload_nxt = RSP_PAYLOAD_W'({fifo_overflow, fifo_count});
            default:      ;
        endcase
    end

    // --- input register / strobe and response registers ---
    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst) begin
            cmd_op        <= OP_NOP;
            req_q         <= 1'b0;
            cmd_addr      <= '0;
            cmd_data      <= '0;
            ack_q         <= 1'b0;
            rsp_op        <= OP_NOP;
            rsp_err       <= 1'b0;
            rsp_payload   <= '0;
            o_kernel_we   <= 1'b0;
            o_kernel_addr <= '0;
            o_kernel_data <= '0;
            o_pixel_valid <= 1'b0;
            o_pixel_data  <= '0;
            o_sop         <= 1'b0;
            o_eop         <= 1'b0;
        end else begin
            if (cmd_load) begin
                cmd_op   <= opcode_t'(i_gpio_data[CMD_OP_HI:CMD_OP_LO]);
                req_q    <= i_gpio_data[CMD_REQ_BIT];
                cmd_addr <= i_gpio_data[CMD_ADDR_HI:CMD_ADDR_LO];
                cmd_data <= i_gpio_data[CMD_DATA_HI:CMD_DATA_LO];
            end

            o_kernel_we   <= exec && (cmd_op == OP_WR_KERNEL) && kernel_ok;
            o_pixel_valid <= exec && (cmd_op == OP_WR_PIXEL);
            o_sop         <= exec && (cmd_op == OP_SOP);
            o_eop         <= exec && (cmd_op == OP_EOP);

            if (exec && (cmd_op == OP_WR_KERNEL) && kernel_ok) begin
                o_kernel_addr <= cmd_addr;
                o_kernel_data <= cmd_data[BIT_LEN-1:0];
            end
            if (exec && (cmd_op == OP_WR_PIXEL)) begin
                o_pixel_data <= cmd_data[BIT_LEN-1:0];
            end

            if (exec) begin
                rsp_op      <= cmd_op;
                rsp_err     <= rsp_err_nxt;
                rsp_payload <= rsp_payload_nxt;
            end
            if (state == ST_ACK) begin
                ack_q <= req_q;
            end
        end
    end

    assign o_gpio_data = GPIO_D'({ack_q, rsp_op, rsp_err, rsp_payload});
    assign o_led       = {fifo_overflow, !fifo_empty, (state != ST_IDLE)};

endmodule
